// File: rtl/image_filter.sv
// Streaming M x N convolution stage: programmable signed kernel, windowed MAC,
// plus an externally supplied partial sum, emitting P results per start.
module image_filter #(
    parameter int M          = 3,
    parameter int N          = 3,
    parameter int P          = 1,
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     kernel_in,
    input  logic [$clog2(M*N)-1:0]    kernel_addr,
    input  logic                      kernel_wen,
    input  logic [DATA_WIDTH-1:0]     pixel_in,
    input  logic                      pixel_valid,
    input  logic [2*DATA_WIDTH-1:0]   matrix_result,
    input  logic                      matrix_valid,
    output logic [2*DATA_WIDTH-1:0]   filter_out,
    output logic                      filter_valid,
    output logic                      filter_done,
    output logic [2:0]                fsm_state
);

    // Handshake: pixel_in/matrix_result are taken on any rising edge where
    // their valid is high in an accepting state; there is no ready/backpressure.

    localparam int              NUM   = M * N;
    localparam int              AW    = $clog2(NUM);
    localparam int              CW    = $clog2(P + 1);
    localparam logic [31:0]     NUM_U = 32'(NUM);
    localparam logic [AW-1:0]   LAST  = AW'(NUM - 1);
    localparam logic [CW-1:0]   P_CNT = CW'(P);
    localparam int              DW    = DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_MAC      = 3'd2,
        S_WAIT_EXT = 3'd3,
        S_EMIT     = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t state, state_next;

    logic signed [DW-1:0] kernel [NUM];
    logic signed [DW-1:0] window [NUM];
    logic [AW-1:0]        idx;
    logic [CW-1:0]        count;
    logic [2*DW-1:0]      acc;
    logic [2*DW-1:0]      ext_val;
    logic                 ext_flag;

    logic signed [2*DW-1:0] k_ext, w_ext, prod;
    logic                   idle_like;
    logic                   ext_accept;

    assign fsm_state  = state;
    assign idle_like  = (state == S_IDLE) || (state == S_DONE);
    assign ext_accept = (state == S_LOAD) || (state == S_MAC) || (state == S_WAIT_EXT);

    // Explicit sign extension keeps the product a full-width signed multiply.
    assign k_ext = {{DW{kernel[idx][DW-1]}}, kernel[idx]};
    assign w_ext = {{DW{window[idx][DW-1]}}, window[idx]};
    assign prod  = k_ext * w_ext;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_next = S_LOAD;
            S_LOAD:         if (pixel_valid && (idx == LAST)) state_next = S_MAC;
            S_MAC:          if (idx == LAST) state_next = S_WAIT_EXT;
            S_WAIT_EXT:     if (ext_flag) state_next = S_EMIT;
            S_EMIT:         state_next = (count == P_CNT) ? S_DONE : S_LOAD;
            default:        state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM; i++) begin
                kernel[i] <= '0;
                window[i] <= '0;
            end
            idx          <= '0;
            count        <= '0;
            acc          <= '0;
            ext_val      <= '0;
            ext_flag     <= 1'b0;
            filter_out   <= '0;
            filter_valid <= 1'b0;
            filter_done  <= 1'b0;
        end else begin
            filter_valid <= 1'b0;

            if (idle_like && kernel_wen && (32'(kernel_addr) < NUM_U))
                kernel[kernel_addr] <= kernel_in;

            // A later pulse overwrites an unconsumed one; consumption below wins.
            if (ext_accept && matrix_valid) begin
                ext_val  <= matrix_result;
                ext_flag <= 1'b1;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        count       <= '0;
                        idx         <= '0;
                        filter_done <= 1'b0;
                        ext_flag    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (pixel_valid) begin
                        window[idx] <= pixel_in;
                        if (idx == LAST) begin
                            idx <= '0;
                            acc <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_MAC: begin
                    acc <= acc + prod;
                    idx <= (idx == LAST) ? '0 : idx + 1'b1;
                end
                S_WAIT_EXT: begin
                    if (ext_flag) begin
                        filter_out   <= acc + ext_val;
                        filter_valid <= 1'b1;
                        ext_flag     <= 1'b0;
                        count        <= count + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (count == P_CNT) filter_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_image_filter.sv
// Directed bench for image_filter: table of single-window runs on a P=1
// instance plus hand sequences for busy writes, P=2 runs and mid-run reset.
module tb_image_filter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, kernel_wen, pixel_valid, matrix_valid;
    logic [7:0]  kernel_in, pixel_in;
    logic [3:0]  kernel_addr;
    logic [15:0] matrix_result;
    logic [15:0] filter_out, filter_out2;
    logic        filter_valid, filter_valid2, filter_done, filter_done2;
    logic [2:0]  fsm_state, fsm_state2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    image_filter #(.M(3), .N(3), .P(1), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .kernel_in(kernel_in), .kernel_addr(kernel_addr), .kernel_wen(kernel_wen),
        .pixel_in(pixel_in), .pixel_valid(pixel_valid),
        .matrix_result(matrix_result), .matrix_valid(matrix_valid),
        .filter_out(filter_out), .filter_valid(filter_valid),
        .filter_done(filter_done), .fsm_state(fsm_state)
    );

    image_filter #(.M(3), .N(3), .P(2), .DATA_WIDTH(8)) dut2 (
        .clk(clk), .rst(rst), .start(start),
        .kernel_in(kernel_in), .kernel_addr(kernel_addr), .kernel_wen(kernel_wen),
        .pixel_in(pixel_in), .pixel_valid(pixel_valid),
        .matrix_result(matrix_result), .matrix_valid(matrix_valid),
        .filter_out(filter_out2), .filter_valid(filter_valid2),
        .filter_done(filter_done2), .fsm_state(fsm_state2)
    );

    typedef struct {
        logic [8:0][7:0] kern;
        logic [8:0][7:0] pix;
        logic [15:0]     ext;
        int              dly;   // <0: during LOAD, 0: none, >0: edges after last pixel
        logic [15:0]     exp;
        int              lat;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic write_kernel(input logic [8:0][7:0] k);
        for (int i = 0; i < 9; i++) begin
            kernel_wen  = 1'b1;
            kernel_addr = 4'(i);
            kernel_in   = k[i];
            tick();
        end
        kernel_wen = 1'b0;
    endtask

    task automatic write_one(input logic [3:0] a, input logic [7:0] d);
        kernel_wen  = 1'b1;
        kernel_addr = a;
        kernel_in   = d;
        tick();
        kernel_wen  = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_window(input logic [8:0][7:0] pix, input logic [15:0] ext,
                               input int dly, output int last_cyc);
        for (int i = 0; i < 9; i++) begin
            pixel_valid = 1'b1;
            pixel_in    = pix[i];
            if (dly < 0 && i == 3) begin
                matrix_valid  = 1'b1;
                matrix_result = ext;
            end
            tick();
            matrix_valid = 1'b0;
        end
        pixel_valid = 1'b0;
        last_cyc    = cyc;
        if (dly > 0) begin
            repeat (dly - 1) tick();
            matrix_valid  = 1'b1;
            matrix_result = ext;
            tick();
            matrix_valid  = 1'b0;
        end
    endtask

    task automatic wait_valid(input bit sel, input string name, output int at);
        at = -1;
        for (int i = 0; i < 60; i++) begin
            if ((sel ? filter_valid2 : filter_valid) === 1'b1) begin
                at = cyc;
                break;
            end
            tick();
        end
        if (at < 0) begin
            total++;
            bad++;
            $display("FAIL %s: got no filter_valid want pulse within 60 cycles", name);
        end
    endtask

    logic [8:0][7:0] ident, seq19, pw;
    int last, at;

    initial begin
        rst = 1'b1; start = 1'b0; kernel_wen = 1'b0; pixel_valid = 1'b0;
        matrix_valid = 1'b0; kernel_in = '0; pixel_in = '0; kernel_addr = '0;
        matrix_result = '0;

        for (int i = 0; i < 9; i++) begin
            ident[i] = (i == 4) ? 8'd1 : 8'd0;
            seq19[i] = 8'(i + 1);
        end

        vecs[0] = '{kern: ident, pix: seq19, ext: 16'd9,    dly: 3,  exp: 16'd14,   lat: 10};
        vecs[1] = '{kern: '1,    pix: seq19, ext: 16'd0,    dly: -1, exp: 16'd45,   lat: 10};
        for (int i = 0; i < 9; i++) vecs[1].kern[i] = 8'd1;
        vecs[2] = '{kern: '0,    pix: '0,    ext: 16'hFFFF, dly: 1,  exp: 16'hFFF7, lat: 10};
        vecs[2].kern[0] = 8'hFF;
        for (int i = 0; i < 9; i++) vecs[2].pix[i] = (i == 0) ? 8'd8 : 8'd5;
        vecs[3] = '{kern: '0,    pix: seq19, ext: 16'd100,  dly: 5,  exp: 16'd145,  lat: 10};
        for (int i = 0; i < 9; i++) vecs[3].kern[i] = (i % 2 == 0) ? 8'(i + 1) : 8'(-(i + 1));
        vecs[4] = '{kern: '0,    pix: '0,    ext: 16'd0,    dly: 9,  exp: 16'h4000, lat: 10};
        for (int i = 0; i < 9; i++) begin vecs[4].kern[i] = 8'h80; vecs[4].pix[i] = 8'h80; end
        vecs[5] = '{kern: '0,    pix: '0,    ext: 16'h8000, dly: 2,  exp: 16'hB709, lat: 10};
        for (int i = 0; i < 9; i++) begin vecs[5].kern[i] = 8'd127; vecs[5].pix[i] = 8'd127; end
        vecs[6] = '{kern: ident, pix: '0,    ext: 16'hFFFE, dly: 12, exp: 16'd12,   lat: 13};
        for (int i = 0; i < 9; i++) vecs[6].pix[i] = 8'(i + 10);

        tick();
        tick();
        chk("rst_out",   filter_out, 0);
        chk("rst_valid", filter_valid, 0);
        chk("rst_done",  filter_done, 0);
        chk("rst_state", fsm_state, 0);
        chk("rst_out2",  filter_out2, 0);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            write_kernel(vecs[v].kern);
            do_start();
            chk($sformatf("v%0d_done_clr", v), filter_done, 0);
            send_window(vecs[v].pix, vecs[v].ext, vecs[v].dly, last);
            wait_valid(1'b0, $sformatf("v%0d_wait", v), at);
            chk($sformatf("v%0d_lat", v), 32'(at - last), 32'(vecs[v].lat));
            chk($sformatf("v%0d_out", v), filter_out, vecs[v].exp);
            tick();
            chk($sformatf("v%0d_pulse", v), filter_valid, 0);
            chk($sformatf("v%0d_done", v), filter_done, 1);
            repeat (3) tick();
            chk($sformatf("v%0d_hold", v), filter_out, vecs[v].exp);
            chk($sformatf("v%0d_done_hold", v), filter_done, 1);
        end

        // Kernel writes out of range or while busy must not land.
        write_kernel(ident);
        write_one(4'd9, 8'd5);
        write_one(4'd15, 8'd3);
        do_start();
        write_one(4'd4, 8'd3);
        write_one(4'd0, 8'd7);
        send_window(seq19, 16'd9, 3, last);
        wait_valid(1'b0, "busy_wr_wait", at);
        chk("busy_wr_out", filter_out, 14);

        // Two windows per start on the P=2 instance; mid-run start is ignored.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        write_kernel(ident);
        do_start();
        for (int i = 0; i < 9; i++) pw[i] = (i == 4) ? 8'd5 : 8'd1;
        send_window(pw, 16'd0, 2, last);
        wait_valid(1'b1, "p2_w1_wait", at);
        chk("p2_w1_out", filter_out2, 5);
        tick();
        chk("p2_w1_pulse", filter_valid2, 0);
        chk("p2_w1_notdone", filter_done2, 0);
        do_start();
        for (int i = 0; i < 9; i++) pw[i] = (i == 4) ? 8'd7 : 8'd2;
        send_window(pw, 16'd1, 3, last);
        wait_valid(1'b1, "p2_w2_wait", at);
        chk("p2_w2_out", filter_out2, 8);
        chk("p2_w2_notdone", filter_done2, 0);
        tick();
        chk("p2_done", filter_done2, 1);
        chk("p2_state", fsm_state2, 5);

        // Reset in the middle of MAC clears outputs, state and the kernel.
        write_kernel(ident);
        do_start();
        send_window(seq19, 16'd0, 0, last);
        repeat (3) tick();
        chk("mac_state", fsm_state, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_out",   filter_out, 0);
        chk("mrst_valid", filter_valid, 0);
        chk("mrst_done",  filter_done, 0);
        chk("mrst_state", fsm_state, 0);
        do_start();
        send_window(seq19, 16'd9, 3, last);
        wait_valid(1'b0, "mrst_zero_wait", at);
        chk("mrst_zero_kernel", filter_out, 9);
        write_kernel(ident);
        do_start();
        send_window(seq19, 16'd9, 3, last);
        wait_valid(1'b0, "mrst_rerun_wait", at);
        chk("mrst_rerun", filter_out, 14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/image_filter.md
# image_filter

Streaming M×N convolution stage of the matrix-processing pipeline. It stores a programmable signed kernel, collects M×N-pixel windows from a pixel stream, and multiplies and accumulates each window against the kernel. It then adds a partial result supplied by the external matrix engine and emits P filtered results per start command.

## Interface
- M, 3, kernel/window rows
- N, 3, kernel/window columns
- P, 1, windows (outputs) processed per start; ≥1
- DATA_WIDTH, 8, signed kernel and pixel width
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset; synchronous and active-high
- start  in  1  begin a run of P windows; honoured only in IDLE or DONE
- kernel_in  in  DATA_WIDTH  signed kernel coefficient
- kernel_addr  in  $clog2(M*N)  coefficient index, raster order (row*N+col)
- kernel_wen  in  1  kernel write strobe
- pixel_in  in  DATA_WIDTH  signed pixel, raster order within window
- pixel_valid  in  1  pixel qualifier
- matrix_result  in  2*DATA_WIDTH  external partial sum for the current window
- matrix_valid  in  1  matrix_result qualifier
- filter_out  out  2*DATA_WIDTH  filtered result (held until next result)
- filter_valid  out  1  one-cycle pulse per result
- filter_done  out  1  level; run of P results complete

## Operation
- Kernel RAM: M*N signed entries, cleared to 0 by reset. Writes occur when kernel_wen=1, but only in IDLE or DONE. kernel_addr ≥ M*N is ignored. Writes in other states are ignored.
- States: IDLE, LOAD, MAC, WAIT_EXT, EMIT, DONE.
- IDLE/DONE: start=1 → LOAD, window count=0, filter_done cleared, ext flag cleared.
- LOAD: each pixel_valid cycle writes pixel_in to window[idx] and increments idx. After the M*N-th pixel → MAC, idx=0. pixel_valid outside LOAD is ignored.
- MAC: one product per cycle, acc += kernel[i]*window[i] (signed DATA_WIDTH×DATA_WIDTH → 2*DATA_WIDTH). The acc cleared on MAC entry. After M*N cycles → WAIT_EXT.
- matrix_valid in LOAD, MAC or WAIT_EXT latches matrix_result and sets the ext flag. A later pulse before consumption overwrites it. It is ignored in IDLE/EMIT/DONE.
- WAIT_EXT: when the ext flag is set → EMIT.
- EMIT (one cycle): filter_out ← acc + ext (modulo 2^(2*DATA_WIDTH), two's complement), filter_valid=1, ext flag cleared, count++. If count==P → DONE; otherwise → LOAD for the next window.
- DONE: filter_done=1, filter_out held. start restarts the run.
- start while busy (LOAD..EMIT) is ignored.
- Accumulation wraps silently; no saturation.

## Timing
- Reset values: filter_out=0, filter_valid=0, filter_done=0, state IDLE, kernel and window all 0, idx and count 0.
- start sampled at edge t → LOAD from t; the first pixel is accepted at edge t+1 or later.
- Last pixel accepted at edge k → MAC occupies edges k+1..k+M*N.
- filter_out and filter_valid are registered and appear on the edge after the later of MAC completion and ext-flag set. filter_valid is high for exactly one cycle.
- filter_done rises on the edge after the P-th filter_valid edge. It stays high until the edge after an accepted start.
- rst=1 at any edge returns every register to its reset value, including mid-run and kernel contents.

## Test plan
- Identity kernel (index 4 = 1, rest 0), start, pixels 1..9, matrix_result=9 three cycles after the last pixel → filter_out=14, one filter_valid pulse, filter_done high and held, filter_out stable.
- All-ones kernel, pixels 1..9, matrix_result=0 sent during LOAD → filter_out=45. The early ext value is retained.
- Kernel index0=-1, rest 0, pixel0=8, matrix_result=16'hFFFF → filter_out=16'hFFF7 (-9), signed wrap.
- Kernel write at addr 9 or during LOAD → no effect; identity result still 14.
- P=2: two windows, identity kernel, centres 5 and 7, ext 0 and 1 → results 5 then 8, two pulses, then done. Extra start while busy is ignored.
- Assert rst during MAC → all outputs 0, IDLE, kernel cleared. A rerun with an identity kernel reload gives the correct result.
